// File: rtl/mem_arbiter.sv
// Purpose: arbitrate I-cache line fills and D-cache fills/write-backs onto one physical memory port.
// Latency: request seen in IDLE at edge N -> memory strobe high during cycle N+1; resp is combinational from pmem_resp.
// Backpressure: one transaction at a time; strobe held until pmem_resp, then one TURN cycle before re-arbitration.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   i_pmem_*                   I-cache side: read request, address, fill data, done pulse
//   d_pmem_*                   D-cache side: read/write request, address, write data, fill data, done pulse
//   pmem_*                     physical memory side: strobes, latched address/wdata, read data, done
//   busy                       high whenever the arbiter is not idle
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        TURN    = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              op_wr_q;
    logic              grant_i, grant_d;
    logic              i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Memory sees only the latched copies, so requester changes mid-service are invisible.
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;
        busy         = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                // On a tie the side that did not win last time gets the port.
                if (i_req && d_req) begin
                    if (last_grant_q == GRANT_I) grant_d = 1'b1;
                    else                         grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
                if (grant_d)      state_d = SERVE_D;
                else if (grant_i) state_d = SERVE_I;
            end
            SERVE_I: begin
                pmem_read    = ~op_wr_q;
                pmem_write   = op_wr_q;
                i_pmem_rdata = pmem_rdata;
                if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    state_d      = TURN;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                pmem_read    = ~op_wr_q;
                pmem_write   = op_wr_q;
                d_pmem_rdata = pmem_rdata;
                if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    state_d      = TURN;
                    last_grant_d = GRANT_D;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction latches: captured only on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= d_pmem_address;
            wdata_q <= d_pmem_wdata;
            op_wr_q <= d_pmem_write;   // write wins when read and write are both raised
        end else if (grant_i) begin
            addr_q  <= i_pmem_address;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, physical address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports, in order:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  i_pmem_read  in  1  I-cache line-fill request
  i_pmem_address  in  ADDR_W  I-cache line address
  i_pmem_rdata  out  LINE_W  fill data to I-cache
  i_pmem_resp  out  1  I-cache transaction done
  d_pmem_read  in  1  D-cache line-fill request
  d_pmem_write  in  1  D-cache write-back request
  d_pmem_address  in  ADDR_W  D-cache line address
  d_pmem_wdata  in  LINE_W  D-cache write-back data
  d_pmem_rdata  out  LINE_W  fill data to D-cache
  d_pmem_resp  out  1  D-cache transaction done
  pmem_read  out  1  physical memory read strobe
  pmem_write  out  1  physical memory write strobe
  pmem_address  out  ADDR_W  physical memory address
  pmem_wdata  out  LINE_W  physical memory write data
  pmem_rdata  in  LINE_W  physical memory read data
  pmem_resp  in  1  physical memory transaction done
  busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, TURN.
REQ-006 In IDLE with only I requesting, SHALL go to SERVE_I on the next edge.
REQ-007 In IDLE with only D requesting (read or write), SHALL go to SERVE_D on the next edge.
REQ-008 In IDLE with both requesting, SHALL grant the side not granted last; the last_grant register resets to I, so D wins the first tie.
REQ-009 On grant, SHALL latch address, op (read/write) and wdata of the winner; pmem_address and pmem_wdata come only from these latches.
REQ-010 In SERVE_x, pmem_read or pmem_write SHALL be asserted from the latched op, held until pmem_resp, and never both high.
REQ-011 If d_pmem_read and d_pmem_write are both high at grant, write SHALL be latched.
REQ-012 On pmem_resp in SERVE_x, x_pmem_resp SHALL assert combinationally for exactly that cycle; the FSM SHALL move to TURN and update last_grant to x.
REQ-013 x_pmem_rdata SHALL equal pmem_rdata whenever SERVE_x; otherwise 0.
REQ-014 The non-granted side's resp SHALL stay 0 throughout.
REQ-015 TURN SHALL last exactly one cycle, with all pmem strobes low, then return to IDLE; requests are re-arbitrated only in IDLE.
REQ-016 Grant-to-strobe latency SHALL be 1 cycle: request seen in IDLE at edge N, strobe high during cycle N+1.
REQ-017 If the granted requester drops its request mid-service, SHALL still hold the strobe until pmem_resp; the resp pulse is still issued.
REQ-018 pmem_resp while IDLE or TURN SHALL be ignored.
REQ-019 A request held continuously through TURN SHALL be considered in the following IDLE; no request is lost or duplicated.

Reset
REQ-020 On rst_n low, SHALL immediately (asynchronously) enter IDLE and drive:
  - pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, busy = 0
  - latched address/wdata = 0
  - last_grant = I
REQ-021 Reset mid-transaction SHALL abort the transaction with no resp pulse; operation SHALL resume from IDLE on the first edge after rst_n rises.

Verification
REQ-022 I-read alone at 0x1230, pmem_resp after 3 cycles, pmem_rdata=0xAA..AA -> pmem_read high for 3 cycles at address 0x1230; one-cycle i_pmem_resp with i_pmem_rdata=0xAA..AA; d_pmem_resp stays 0.
REQ-023 I-read and D-write issued the same cycle after reset -> D served first (pmem_write, d_pmem_wdata passed through); TURN; then I served; resp pulses are in D, I order.
REQ-024 Both sides request continuously for 6 transactions -> grants alternate D,I,D,I,D,I; each grant is separated by exactly one TURN cycle.
REQ-025 D-write in service, d_pmem_address changes mid-service -> pmem_address keeps the latched value until resp.
REQ-026 rst_n pulsed low during SERVE_I -> pmem_read drops without waiting for a clock edge; no i_pmem_resp; a new I-read after reset is served normally.
